// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by the UART register window.
interface mmio_uart_tx_if;
  logic        ce;
  logic        we;
  logic        memRr;
  logic [31:0] addr;
  logic [31:0] wtData;
  logic [3:0]  w_mask;
  logic [3:0]  r_mask;
  logic [31:0] rdData;

  modport master (
    output ce, we, memRr, addr, wtData, w_mask, r_mask,
    input  rdData
  );

  modport slave (
    input  ce, we, memRr, addr, wtData, w_mask, r_mask,
    output rdData
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, status and baud divisor registers.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] CLK_DIV    = 16'd16
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  txState_t          state;
  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [15:0]       divReg;
  logic [7:0]        shiftReg;
  logic [2:0]        bitIdx;
  logic [15:0]       divCnt;
  logic [15:0]       bitPeriod;

  logic              hit;
  logic [1:0]        regSel;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              pushReq;
  logic              pushOk;
  logic              popOk;
  logic              ovfClr;
  logic              divWrite;
  logic [15:0]       effPeriod;
  logic              bitDone;
  logic [7:0]        fifoHead;
  logic [3:0]        countSat;
  logic [31:0]       statusWord;
  logic [31:0]       rdWord;
  logic              unusedBits;

  // Address decode and request qualification
  assign hit       = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign regSel    = bus.addr[3:2];
  assign fifoFull  = (count == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (count == '0);
  assign pushReq   = hit && bus.we && (regSel == REG_TXDATA) && bus.w_mask[0];
  assign pushOk    = pushReq && !fifoFull;
  assign popOk     = (state == IDLE) && !fifoEmpty;
  assign ovfClr    = hit && bus.we && (regSel == REG_STATUS) && bus.w_mask[0] && bus.wtData[3];
  assign divWrite  = hit && bus.we && (regSel == REG_DIV);
  assign fifoHead  = fifoMem[rdPtr];

  // A zero divisor still needs one clock per bit
  assign effPeriod = (divReg == 16'd0) ? 16'd1 : divReg;
  assign bitDone   = (divCnt == (bitPeriod - 16'd1));

  assign countSat   = (count > CNT_W'(15)) ? 4'hF : 4'(count);
  assign statusWord = {24'd0, countSat, ovf, (state != IDLE), fifoEmpty, fifoFull};

  // Interrupt when nothing is left to send
  assign irq = fifoEmpty && (state == IDLE);

  // Same-cycle register read for the single-cycle CPU
  always_comb begin
    rdWord = 32'h0;
    if (hit && bus.memRr && !bus.we) begin
      case (regSel)
        REG_STATUS: rdWord = statusWord;
        REG_DIV:    rdWord = {16'd0, divReg};
        default:    rdWord = 32'h0;
      endcase
    end
  end

  assign bus.rdData = rdWord;

  // Read mask, byte offset and upper write bits carry no meaning here
  assign unusedBits = ^{bus.r_mask, bus.addr[1:0], bus.wtData[31:16]};

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= bus.wtData[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popOk) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (pushOk && !popOk) begin
        count <= count + CNT_W'(1);
      end else if (!pushOk && popOk) begin
        count <= count - CNT_W'(1);
      end
      if (pushReq && fifoFull) begin
        ovf <= 1'b1;
      end else if (ovfClr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Baud divisor register with per-byte write enables
  always_ff @(posedge clk) begin
    if (rst) begin
      divReg <= CLK_DIV;
    end else if (divWrite) begin
      if (bus.w_mask[0]) begin
        divReg[7:0] <= bus.wtData[7:0];
      end
      if (bus.w_mask[1]) begin
        divReg[15:8] <= bus.wtData[15:8];
      end
    end
  end

  // Frame sequencer; bit period is re-latched at every bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shiftReg  <= 8'd0;
      bitIdx    <= 3'd0;
      divCnt    <= 16'd0;
      bitPeriod <= 16'd1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifoEmpty) begin
            shiftReg  <= fifoHead;
            bitIdx    <= 3'd0;
            divCnt    <= 16'd0;
            bitPeriod <= effPeriod;
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bitDone) begin
            divCnt    <= 16'd0;
            bitPeriod <= effPeriod;
            tx        <= shiftReg[0];
            state     <= DATA;
          end else begin
            divCnt <= divCnt + 16'd1;
          end
        end
        DATA: begin
          if (bitDone) begin
            divCnt    <= 16'd0;
            bitPeriod <= effPeriod;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              tx       <= shiftReg[1];
            end
          end else begin
            divCnt <= divCnt + 16'd1;
          end
        end
        STOP: begin
          if (bitDone) begin
            divCnt <= 16'd0;
            tx     <= 1'b1;
            state  <= IDLE;
          end else begin
            divCnt <= divCnt + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: frame decoder and register-read monitor.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8),
    .CLK_DIV   (16'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cycleNo = 0;
  logic [7:0]  expQ [$];
  logic [31:0] rdExpQ [$];
  string       rdNameQ [$];
  logic [15:0] tbDiv = 16'd16;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic idleBus();
    bus.ce = 1'b0; bus.we = 1'b0; bus.memRr = 1'b0;
    bus.addr = 32'h0; bus.wtData = 32'h0; bus.w_mask = 4'h0; bus.r_mask = 4'h0;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.ce = 1'b1; bus.we = 1'b1; bus.memRr = 1'b0;
    bus.addr = a; bus.wtData = d; bus.w_mask = m;
    @(posedge clk); #1;
    idleBus();
  endtask

  task automatic busRead(input logic [31:0] a, input logic [31:0] expv, input string nm);
    rdExpQ.push_back(expv);
    rdNameQ.push_back(nm);
    bus.ce = 1'b1; bus.we = 1'b0; bus.memRr = 1'b1; bus.addr = a; bus.r_mask = 4'hF;
    @(posedge clk); #1;
    idleBus();
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask

  task automatic waitIrq(input int limit);
    int cyc;
    cyc = 0;
    while (irq !== 1'b1 && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Monitor: compares register reads and decodes serial frames cycle by cycle
  bit         mActive = 1'b0;
  bit         mBad;
  bit         mNoExp;
  int         mPh;
  int         mCnt;
  int         mPer;
  logic [7:0] mExp;
  logic [7:0] mGot;
  logic       lvl;

  always @(negedge clk) begin
    if (rst) begin
      if (mActive) begin
        checks++;
        if (mBad) begin
          errors++;
          $display("FAIL aborted_frame got=%h exp=%h", mGot, mExp);
        end
      end
      mActive = 1'b0;
    end else begin
      if (bus.ce && bus.memRr && !bus.we) begin
        checks++;
        if (rdExpQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read got=%h exp=none", bus.rdData);
        end else begin
          logic [31:0] ev;
          string       nm;
          ev = rdExpQ.pop_front();
          nm = rdNameQ.pop_front();
          if (bus.rdData !== ev) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, bus.rdData, ev);
          end
        end
      end
      if (!mActive) begin
        if (tx === 1'b0) begin
          mActive = 1'b1; mPh = 0; mCnt = 1; mBad = 1'b0; mGot = 8'h0;
          mPer = (tbDiv == 16'd0) ? 1 : int'(tbDiv);
          if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame got=start exp=idle");
            mNoExp = 1'b1; mExp = 8'h0;
          end else begin
            mNoExp = 1'b0; mExp = expQ.pop_front();
          end
        end
      end else begin
        if (mCnt == mPer) begin mPh++; mCnt = 1; end
        else mCnt++;
        if (mPh == 0) lvl = 1'b0;
        else if (mPh == 9) lvl = 1'b1;
        else lvl = mExp[3'(mPh - 1)];
        if (mPh >= 1 && mPh <= 8 && mCnt == 1) mGot[3'(mPh - 1)] = tx;
        if (!mNoExp && tx !== lvl) mBad = 1'b1;
        if (mPh == 9 && mCnt == mPer) begin
          mActive = 1'b0;
          if (!mNoExp) begin
            checks++;
            if (mBad) begin
              errors++;
              $display("FAIL frame got=%h exp=%h", mGot, mExp);
            end
          end
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int startCyc;
    idleBus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_tx", tx, 1);
    check("reset_irq", irq, 1);
    busRead(A_ST, 32'h2, "reset_status");
    busRead(A_DIV, 32'd16, "reset_div");
    busRead(A_TX, 32'h0, "read_txdata");
    busRead(A_RSV, 32'h0, "read_rsvd");

    // Single frame 0xA5 at DIV=4
    busWrite(A_DIV, 32'd4, 4'b0011);
    tbDiv = 16'd4;
    busRead(A_DIV, 32'd4, "div_4");
    expQ.push_back(8'hA5);
    busWrite(A_TX, 32'hA5, 4'b0001);
    check("a5_tx_at_push", tx, 1);
    check("a5_irq_after_push", irq, 0);
    @(posedge clk); #1;
    check("a5_tx_start", tx, 0);
    startCyc = cycleNo;
    busRead(A_ST, 32'h6, "status_busy");
    waitIrq(200);
    check("a5_irq_done", irq, 1);
    check("a5_frame_len", 32'(cycleNo - startCyc), 32'd40);

    // Fill FIFO while a frame is in flight, then overflow
    for (int i = 0; i < 9; i++) begin
      expQ.push_back(8'(i));
      busWrite(A_TX, 32'(i), 4'b0001);
    end
    busRead(A_ST, 32'h85, "status_full");
    busWrite(A_TX, 32'h09, 4'b0001);
    busRead(A_ST, 32'h8D, "status_ovf");
    busWrite(A_ST, 32'h8, 4'b0001);
    busRead(A_ST, 32'h85, "status_ovf_clr");
    waitIrq(600);
    check("drain_irq", irq, 1);
    check("drain_queue_empty", 32'(expQ.size()), 32'd0);
    busRead(A_ST, 32'h2, "status_drained");

    // Masked and out-of-window accesses
    busWrite(A_TX, 32'h77, 4'b0010);
    busWrite(BASE + 32'h10, 32'h77, 4'b0001);
    busRead(A_ST, 32'h2, "status_no_push");
    check("irq_no_push", irq, 1);
    busRead(BASE + 32'h10, 32'h0, "read_outside");
    busRead(BASE + 32'h14, 32'h0, "read_outside_status");
    busWrite(A_DIV, 32'h9, 4'b0000);
    busRead(A_DIV, 32'd4, "div_mask0");
    busWrite(A_DIV, 32'hFFFF_12FF, 4'b0010);
    busRead(A_DIV, 32'h1204, "div_hi_byte");
    bus.ce = 1'b1; bus.we = 1'b1; bus.memRr = 1'b1; bus.addr = A_DIV; bus.w_mask = 4'h0;
    #2;
    check("read_while_we", bus.rdData, 32'h0);
    @(posedge clk); #1;
    idleBus();
    busWrite(A_DIV, 32'd4, 4'b0011);
    busRead(A_DIV, 32'd4, "div_restore");

    // Reset in the middle of a frame discards it and the queued byte
    expQ.push_back(8'h5A);
    busWrite(A_TX, 32'h5A, 4'b0001);
    busWrite(A_TX, 32'h33, 4'b0001);
    repeat (16) begin @(posedge clk); #1; end
    rst = 1'b1;
    expQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    tbDiv = 16'd16;
    check("midreset_tx", tx, 1);
    check("midreset_irq", irq, 1);
    busRead(A_ST, 32'h2, "midreset_status");
    busRead(A_DIV, 32'd16, "midreset_div");
    repeat (40) begin @(posedge clk); #1; end
    check("midreset_still_idle", irq, 1);

    // DIV=0 behaves as one cycle per bit
    busWrite(A_DIV, 32'd0, 4'b0011);
    tbDiv = 16'd0;
    expQ.push_back(8'h01);
    busWrite(A_TX, 32'h01, 4'b0001);
    @(posedge clk); #1;
    check("div0_tx_start", tx, 0);
    startCyc = cycleNo;
    waitIrq(100);
    check("div0_irq_done", irq, 1);
    check("div0_frame_len", 32'(cycleNo - startCyc), 32'd10);
    busRead(A_ST, 32'h2, "div0_status");

    repeat (5) begin @(posedge clk); #1; end
    check("final_frames_left", 32'(expQ.size()), 32'd0);
    check("final_reads_left", 32'(rdExpQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
